// File: rtl/mod5_pkg.sv
// Shared mod-5 definitions: state encoding and value helpers
// reused by every block that produces or checks a mod-5 stream.
package mod5_pkg;

  localparam logic [2:0] MOD5_MAX = 3'd4;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } mod5_state_e;

  function automatic logic [2:0] mod5_next(input logic [2:0] v);
    return (v >= MOD5_MAX) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic mod5_legal(input logic [2:0] v);
    return v <= MOD5_MAX;
  endfunction

endpackage

// File: rtl/mod5_sequence_checker.sv
// Receive-side monitor for a mod-5 count stream: locks after a run
// of correct transitions, then flags breaks and counts wraps.
module mod5_sequence_checker
  import mod5_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8,
  parameter int WRAP_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2:0]        d_in,
  input  logic              clear_counts,
  output logic              locked,
  output logic [2:0]        expected,
  output logic              err_pulse,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  mod5_state_e      state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic             pv_q, pv_d;
  logic [3:0]       streak_q, streak_d;
  logic [2:0]       exp_q, exp_d;
  logic             errp_q, errp_d;
  logic             wrapp_q, wrapp_d;
  logic [ERR_W-1:0] err_q;
  logic [WRAP_W-1:0] wrap_q;

  logic legal;
  logic hit;

  assign legal = mod5_legal(d_in);
  assign hit   = legal && pv_q && (d_in == mod5_next(prev_q));

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    pv_d     = pv_q;
    streak_d = streak_q;
    errp_d   = 1'b0;
    wrapp_d  = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        UNLOCKED: begin
          if (!legal) begin
            pv_d     = 1'b0;
            streak_d = 4'd0;
          end else begin
            prev_d = d_in;
            pv_d   = 1'b1;
            if (!hit) begin
              streak_d = 4'd0;
            end else if (streak_q + 4'd1 == LOCK_N) begin
              state_d  = LOCKED;
              streak_d = 4'd0;
            end else begin
              streak_d = streak_q + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (hit) begin
            prev_d  = d_in;
            wrapp_d = (d_in == 3'd0);
          end else begin
            errp_d   = 1'b1;
            state_d  = UNLOCKED;
            streak_d = 4'd0;
            pv_d     = legal;
            if (legal) prev_d = d_in;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
    exp_d = pv_d ? mod5_next(prev_d) : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= UNLOCKED;
      prev_q   <= 3'd0;
      pv_q     <= 1'b0;
      streak_q <= 4'd0;
      exp_q    <= 3'd0;
      errp_q   <= 1'b0;
      wrapp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      pv_q     <= pv_d;
      streak_q <= streak_d;
      exp_q    <= exp_d;
      errp_q   <= errp_d;
      wrapp_q  <= wrapp_d;
    end
  end

  // Saturating error counter; clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (!reset || clear_counts) begin
      err_q <= '0;
    end else if (errp_d && err_q != '1) begin
      err_q <= err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear_counts) begin
      wrap_q <= '0;
    end else if (wrapp_d) begin
      wrap_q <= wrap_q + 1'b1;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign expected   = exp_q;
  assign err_pulse  = errp_q;
  assign wrap_pulse = wrapp_q;
  assign err_count  = err_q;
  assign wrap_count = wrap_q;

endmodule

// File: tb/tb_mod5_sequence_checker.sv
// Directed bench for mod5_sequence_checker; a second instance with
// a 2-bit error counter shares the stimulus for saturation checks.
module tb_mod5_sequence_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  d_in = 3'd0;
  logic        clear_counts = 1'b0;

  logic        locked, locked2;
  logic [2:0]  expected, expected2;
  logic        err_pulse, err_pulse2;
  logic        wrap_pulse, wrap_pulse2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;
  logic [15:0] wrap_count, wrap_count2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mod5_sequence_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .d_in(d_in),
    .clear_counts(clear_counts), .locked(locked), .expected(expected),
    .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  mod5_sequence_checker #(.LOCK_COUNT(3), .ERR_W(2), .WRAP_W(16)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .d_in(d_in),
    .clear_counts(clear_counts), .locked(locked2), .expected(expected2),
    .err_pulse(err_pulse2), .wrap_pulse(wrap_pulse2),
    .err_count(err_count2), .wrap_count(wrap_count2)
  );

  task automatic step(input logic v, input logic [2:0] d, input logic clr);
    @(negedge clk);
    reset = 1'b1;
    in_valid = v;
    d_in = d;
    clear_counts = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear_counts = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    d_in = 3'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({locked, expected, err_pulse, wrap_pulse} !== 6'd0 ||
        err_count !== 8'd0 || wrap_count !== 16'd0) begin
      $display("FAIL reset: locked=%b exp=%0d ep=%b wp=%b err=%0d wrap=%0d want all 0",
               locked, expected, err_pulse, wrap_pulse, err_count, wrap_count);
    end else passed++;
  endtask

  task automatic test_lock();
    step(1, 0, 0);
    total++;
    if (locked !== 1'b0 || expected !== 3'd1)
      $display("FAIL lock_first: locked=%b exp=%0d want 0/1", locked, expected);
    else passed++;
    step(1, 1, 0);
    step(1, 2, 0);
    total++;
    if (locked !== 1'b0)
      $display("FAIL lock_early: locked=%b want 0", locked);
    else passed++;
    step(1, 3, 0);
    total++;
    if (locked !== 1'b1 || expected !== 3'd4 || err_count !== 8'd0)
      $display("FAIL lock: locked=%b exp=%0d err=%0d want 1/4/0",
               locked, expected, err_count);
    else passed++;
  endtask

  task automatic test_wrap();
    step(1, 4, 0);
    total++;
    if (wrap_pulse !== 1'b0 || expected !== 3'd0)
      $display("FAIL wrap_pre: wp=%b exp=%0d want 0/0", wrap_pulse, expected);
    else passed++;
    step(1, 0, 0);
    total++;
    if (wrap_pulse !== 1'b1 || wrap_count !== 16'd1 || expected !== 3'd1)
      $display("FAIL wrap: wp=%b wrap=%0d exp=%0d want 1/1/1",
               wrap_pulse, wrap_count, expected);
    else passed++;
    step(1, 1, 0);
    total++;
    if (wrap_pulse !== 1'b0 || wrap_count !== 16'd1 || locked !== 1'b1)
      $display("FAIL wrap_post: wp=%b wrap=%0d locked=%b want 0/1/1",
               wrap_pulse, wrap_count, locked);
    else passed++;
  endtask

  task automatic test_break();
    step(1, 2, 0);
    step(1, 4, 0);
    total++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 ||
        expected !== 3'd0)
      $display("FAIL break: ep=%b err=%0d locked=%b exp=%0d want 1/1/0/0",
               err_pulse, err_count, locked, expected);
    else passed++;
    step(1, 0, 0);
    total++;
    if (err_pulse !== 1'b0 || wrap_pulse !== 1'b0)
      $display("FAIL break_pulse: ep=%b wp=%b want 0/0", err_pulse, wrap_pulse);
    else passed++;
    step(1, 1, 0);
    total++;
    if (locked !== 1'b0)
      $display("FAIL relock_early: locked=%b want 0", locked);
    else passed++;
    step(1, 2, 0);
    total++;
    if (locked !== 1'b1 || expected !== 3'd3)
      $display("FAIL relock: locked=%b exp=%0d want 1/3", locked, expected);
    else passed++;
  endtask

  task automatic test_illegal();
    step(1, 6, 0);
    total++;
    if (err_pulse !== 1'b1 || locked !== 1'b0 || expected !== 3'd0 ||
        err_count !== 8'd2)
      $display("FAIL illegal: ep=%b locked=%b exp=%0d err=%0d want 1/0/0/2",
               err_pulse, locked, expected, err_count);
    else passed++;
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 2, 0);
    total++;
    if (locked !== 1'b0 || expected !== 3'd3)
      $display("FAIL illegal_early: locked=%b exp=%0d want 0/3", locked, expected);
    else passed++;
    step(1, 3, 0);
    total++;
    if (locked !== 1'b1)
      $display("FAIL illegal_relock: locked=%b want 1", locked);
    else passed++;
  endtask

  task automatic test_sat_clear();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      total++;
      if (err_pulse !== 1'b1 || locked !== 1'b0)
        $display("FAIL sat_break%0d: ep=%b locked=%b want 1/0", i, err_pulse, locked);
      else passed++;
      step(1, 1, 0);
      step(1, 2, 0);
      step(1, 3, 0);
    end
    total++;
    if (err_count !== 8'd7 || err_count2 !== 2'd3 || locked2 !== 1'b1)
      $display("FAIL sat: err=%0d err2=%0d locked2=%b want 7/3/1",
               err_count, err_count2, locked2);
    else passed++;
    step(1, 0, 1);
    total++;
    if (err_count !== 8'd0 || err_count2 !== 2'd0 || wrap_count !== 16'd0 ||
        err_pulse !== 1'b1 || locked !== 1'b0)
      $display("FAIL clear: err=%0d err2=%0d wrap=%0d ep=%b locked=%b want 0/0/0/1/0",
               err_count, err_count2, wrap_count, err_pulse, locked);
    else passed++;
  endtask

  task automatic test_gaps_reset();
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 5, 0);
    total++;
    if (locked !== 1'b0 || expected !== 3'd1 || err_pulse !== 1'b0)
      $display("FAIL gap_hold: locked=%b exp=%0d ep=%b want 0/1/0",
               locked, expected, err_pulse);
    else passed++;
    step(1, 1, 0);
    step(1, 2, 0);
    step(1, 3, 0);
    total++;
    if (locked !== 1'b1 || expected !== 3'd4)
      $display("FAIL gap_lock: locked=%b exp=%0d want 1/4", locked, expected);
    else passed++;
    step(1, 4, 0);
    step(1, 0, 0);
    total++;
    if (wrap_count !== 16'd1)
      $display("FAIL gap_wrap: wrap=%0d want 1", wrap_count);
    else passed++;
    do_reset();
    total++;
    if ({locked, expected, err_pulse, wrap_pulse} !== 6'd0 ||
        err_count !== 8'd0 || wrap_count !== 16'd0)
      $display("FAIL mid_reset: locked=%b exp=%0d ep=%b wp=%b err=%0d wrap=%0d want all 0",
               locked, expected, err_pulse, wrap_pulse, err_count, wrap_count);
    else passed++;
    step(1, 1, 0);
    step(1, 2, 0);
    step(1, 3, 0);
    total++;
    if (locked !== 1'b0 || expected !== 3'd4)
      $display("FAIL post_reset: locked=%b exp=%0d want 0/4", locked, expected);
    else passed++;
    step(1, 4, 0);
    total++;
    if (locked !== 1'b1)
      $display("FAIL post_reset_lock: locked=%b want 1", locked);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_break();
    test_illegal();
    test_sat_clear();
    test_gaps_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mod5_sequence_checker.md
# mod5_sequence_checker

Receive-side monitor for the 3-bit mod-5 count stream (0,1,2,3,4,0,…) produced by the team's mod-5 counter. It samples the stream on a valid strobe and locks onto the sequence after a run of correct transitions. Once locked, it flags every break in the sequence and counts completed wraps. It sits downstream of any mod-5 source, such as a clock-divider phase or a frame slot index, as a self-check and health monitor.

## Interface
Parameters:
- LOCK_COUNT, default 3: consecutive correct transitions required to lock (legal range 1–15).
- ERR_W, default 8: width of the error counter.
- WRAP_W, default 16: width of the wrap counter.

Ports:
- clk  in  1  — system clock; all logic is on the rising edge.
- reset  in  1  — synchronous, active-low reset.
- in_valid  in  1  — d_in is sampled when this is high.
- d_in  in  3  — incoming count value.
- clear_counts  in  1  — synchronous clear of err_count and wrap_count.
- locked  out  1  — high while in LOCKED.
- expected  out  3  — next value the checker expects; 0 when there is no history.
- err_pulse  out  1  — one-cycle pulse on a sequence break while locked.
- wrap_pulse  out  1  — one-cycle pulse on a correct 4→0 transition while locked.
- err_count  out  ERR_W  — number of sequence breaks; saturates at all-ones.
- wrap_count  out  WRAP_W  — number of completed wraps; rolls over modulo 2^WRAP_W.

## Operation
Reset (reset low at a clock edge):
- All outputs go to 0.
- Internal state: prev_valid=0, streak=0, state=UNLOCKED.

Definitions:
- next(v) is v+1 for v in 0..3, and 0 for v=4.
- A value is legal if it is ≤ 4. Values 5–7 are illegal.

Cycles with in_valid low: all state holds; pulses are 0.

UNLOCKED state, on a valid sample:
- Illegal value: prev_valid←0, streak←0.
- Legal value, prev_valid=1, and d_in==next(prev): streak←streak+1.
- Any other legal value: streak←0.
- Every legal value sets prev←d_in and prev_valid←1.
- When the increment makes streak reach LOCK_COUNT: state←LOCKED, streak←0.
- No err_pulse is generated while unlocked.

LOCKED state, on a valid sample:
- d_in==next(prev): prev←d_in. If d_in==0, assert wrap_pulse and increment wrap_count.
- Mismatch (including an illegal value):
  - Assert err_pulse; err_count increments with saturation.
  - state←UNLOCKED, streak←0.
  - If d_in is legal: prev←d_in, prev_valid←1. If illegal: prev_valid←0.
  - No wrap_pulse is generated on a mismatch, even when d_in is 0.

Outputs:
- expected is next(prev) when prev_valid=1, otherwise 0. It updates together with prev.

clear_counts:
- Zeroes err_count and wrap_count.
- If a clear coincides with an increment, the clear wins: the count ends at 0.
- Has no effect on lock state or pulses.

Reset asserted mid-sequence: everything returns to reset values at that edge, and the next lock again needs LOCK_COUNT fresh transitions.

## Timing
- All outputs are registered.
- A sample taken at edge k drives locked, expected, the pulses and the counters from edge k onward, i.e. visible in the cycle after the sample.
- Pulses last exactly one cycle per qualifying sample. Back-to-back errors are impossible because the first error unlocks the checker.
- Lock latency from an unlocked state with no history: LOCK_COUNT+1 valid samples. locked rises at the edge of the last sample.
- in_valid gaps do not break a streak; only the values matter.

## Structure
- Shared package mod5_pkg holds:
  - MOD5_MAX = 3'd4;
  - the state enum {UNLOCKED, LOCKED};
  - function mod5_next(v) returning 3 bits;
  - function mod5_legal(v).
- The mod-5 counter and any future mod-5 block reuse this package.
- Single module; no sub-module. The saturating and wrapping counters are inline always blocks.

## Test plan
- Lock: reset, then drive 0,1,2,3 valid on consecutive cycles → locked=1 after the edge of the "3" sample; expected=4; err_count=0.
- Wrap: while locked, drive 4,0 → wrap_pulse for one cycle after the 0 sample; wrap_count=1; a following 1 gives no pulse.
- Break: locked with prev=2, drive 4 → err_pulse=1, err_count=1, locked=0, expected=0 (next of 4). Then 0,1,2 → relock.
- Illegal value: locked, drive 6 → err_pulse, locked=0, expected=0. Then 0,1,2,3 are needed to relock (LOCK_COUNT=3).
- Saturation and clear: ERR_W=2, force 5 breaks → err_count stays 3. Assert clear_counts in the same cycle as a break → err_count=0.
- Gaps and reset: drive 0, in_valid low 4 cycles, then 1,2,3 → locked. Then pull reset low mid-stream → all outputs 0 at that edge.
